// File: rtl/instr_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction sequencer (master)
// and the fetch/memory/decode/datapath side (slave).
interface instr_sequencer_if #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned RET_W = 16
);
    logic             Run;
    logic             Fetch_Ack;
    logic             Mem_Ack;
    logic [3:0]       Decode;
    logic [CNT_W-1:0] CntIn;
    logic             CondPass;

    logic             Fetch_Req;
    logic             IR_Load;
    logic             PC_Inc;
    logic             RegRd_En;
    logic             ALU_En;
    logic             Mem_Req;
    logic             Mem_Wr;
    logic             RegWr_En;
    logic [CNT_W-1:0] CntOut;
    logic             Busy;
    logic             InstrDone;
    logic [RET_W-1:0] RetCount;

    modport master (
        input  Run, Fetch_Ack, Mem_Ack, Decode, CntIn, CondPass,
        output Fetch_Req, IR_Load, PC_Inc, RegRd_En, ALU_En, Mem_Req, Mem_Wr, RegWr_En,
               CntOut, Busy, InstrDone, RetCount
    );

    modport slave (
        output Run, Fetch_Ack, Mem_Ack, Decode, CntIn, CondPass,
        input  Fetch_Req, IR_Load, PC_Inc, RegRd_En, ALU_En, Mem_Req, Mem_Wr, RegWr_En,
               CntOut, Busy, InstrDone, RetCount
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and write-back phases,
// with PC increment, control-word latching and a retired-instruction counter.
module instr_sequencer #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned RET_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    instr_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5
    } state_e;

    localparam logic [3:0] ClsNone  = 4'd0;
    localparam logic [3:0] ClsLoad  = 4'd9;
    localparam logic [3:0] ClsStore = 4'd10;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       cls_q;
    logic [RET_W-1:0] ret_q;
    logic             retire;
    logic             annul;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cls_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                cnt_q <= bus.CntIn;
                cls_q <= bus.Decode;
            end
            if (retire) begin
                ret_q <= ret_q + RET_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.Run) state_d = StFetch;
            StFetch:  if (bus.Fetch_Ack) state_d = StDecode;
            StDecode: begin
                if (!bus.CondPass) state_d = bus.Run ? StFetch : StIdle;
                else               state_d = StExec;
            end
            StExec: begin
                if (cls_q == ClsLoad || cls_q == ClsStore) state_d = StMem;
                else if (cls_q == ClsNone)                 state_d = bus.Run ? StFetch : StIdle;
                else                                       state_d = StWb;
            end
            StMem: begin
                if (bus.Mem_Ack) begin
                    // Only loads and stores reach this state; loads still need write-back.
                    if (cls_q == ClsLoad) state_d = StWb;
                    else                  state_d = bus.Run ? StFetch : StIdle;
                end
            end
            StWb:     state_d = bus.Run ? StFetch : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.Fetch_Req = 1'b0;
        bus.IR_Load   = 1'b0;
        bus.PC_Inc    = 1'b0;
        bus.RegRd_En  = 1'b0;
        bus.ALU_En    = 1'b0;
        bus.Mem_Req   = 1'b0;
        bus.Mem_Wr    = 1'b0;
        bus.RegWr_En  = 1'b0;
        retire        = 1'b0;
        annul         = 1'b0;
        case (state_q)
            StFetch: begin
                bus.Fetch_Req = 1'b1;
                bus.IR_Load   = bus.Fetch_Ack;
                bus.PC_Inc    = bus.Fetch_Ack;
            end
            StDecode: begin
                bus.RegRd_En = 1'b1;
                annul        = !bus.CondPass;
            end
            StExec: begin
                bus.ALU_En = 1'b1;
                retire     = (cls_q == ClsNone);
            end
            StMem: begin
                bus.Mem_Req = 1'b1;
                bus.Mem_Wr  = (cls_q == ClsStore);
                retire      = bus.Mem_Ack && (cls_q == ClsStore);
            end
            StWb: begin
                bus.RegWr_En = 1'b1;
                retire       = 1'b1;
            end
            default: ;
        endcase
        bus.Busy      = (state_q != StIdle);
        bus.InstrDone = retire | annul;
    end

    assign bus.CntOut   = cnt_q;
    assign bus.RetCount = ret_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-instruction expected traces compared every cycle,
// plus literal latency/counter checks.
module tb_instr_sequencer;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned RET_W = 4;  // narrow counter so wrap is reachable quickly

    // Strobe vector bit positions
    localparam logic [9:0] BF  = 10'b10_0000_0000;  // Fetch_Req
    localparam logic [9:0] BIR = 10'b01_0000_0000;  // IR_Load
    localparam logic [9:0] BPC = 10'b00_1000_0000;  // PC_Inc
    localparam logic [9:0] BRD = 10'b00_0100_0000;  // RegRd_En
    localparam logic [9:0] BA  = 10'b00_0010_0000;  // ALU_En
    localparam logic [9:0] BM  = 10'b00_0001_0000;  // Mem_Req
    localparam logic [9:0] BW  = 10'b00_0000_1000;  // Mem_Wr
    localparam logic [9:0] BR  = 10'b00_0000_0100;  // RegWr_En
    localparam logic [9:0] BB  = 10'b00_0000_0010;  // Busy
    localparam logic [9:0] BD  = 10'b00_0000_0001;  // InstrDone

    typedef struct {
        logic [9:0]       s;
        logic [CNT_W-1:0] cnt;
        logic [RET_W-1:0] ret;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    instr_sequencer_if #(.CNT_W(CNT_W), .RET_W(RET_W)) bus ();

    instr_sequencer #(.CNT_W(CNT_W), .RET_W(RET_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    exp_t             q[$];
    exp_t             e;
    logic [9:0]       act;
    int               tests = 0;
    int               fails = 0;
    int               cycle = 0;
    logic [CNT_W-1:0] m_cnt;
    logic [RET_W-1:0] m_ret;
    int               idx;
    int               lat_m;
    int               lat;

    always @(negedge CLK) begin
        cycle <= cycle + 1;
        if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.Fetch_Req, bus.IR_Load, bus.PC_Inc, bus.RegRd_En, bus.ALU_En,
                   bus.Mem_Req, bus.Mem_Wr, bus.RegWr_En, bus.Busy, bus.InstrDone};
            tests++;
            if (act !== e.s || bus.CntOut !== e.cnt || bus.RetCount !== e.ret) begin
                fails++;
                $display("FAIL cycle_%0d: strobes=%b CntOut=%h RetCount=%h, required strobes=%b CntOut=%h RetCount=%h",
                         cycle, act, bus.CntOut, bus.RetCount, e.s, e.cnt, e.ret);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, note when InstrDone shows up.
    task automatic cyc(input logic run, input logic fack, input logic mack, input logic [9:0] s);
        exp_t x;
        bus.Run       = run;
        bus.Fetch_Ack = fack;
        bus.Mem_Ack   = mack;
        x.s   = s;
        x.cnt = m_cnt;
        x.ret = m_ret;
        q.push_back(x);
        #3;
        if (bus.InstrDone === 1'b1 && lat_m < 0) lat_m = idx + 1;
        idx++;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cyc(input logic run);
        cyc(run, 1'b1, 1'b1, 10'b0);  // stray acks must be ignored in IDLE
    endtask

    // Whole instruction starting in its FETCH cycle; returns FETCH-entry-to-InstrDone latency.
    task automatic run_instr(input logic [3:0] cls, input logic [CNT_W-1:0] cnt, input logic cond,
                             input int fwait, input int mwait, input logic run_end,
                             output int latency);
        logic [9:0] wr;
        idx   = 0;
        lat_m = -1;
        bus.Decode   = cls;
        bus.CntIn    = cnt;
        bus.CondPass = cond;
        for (int i = 0; i < fwait; i++) cyc(1'b1, 1'b0, 1'b1, BF | BB);
        cyc(1'b1, 1'b1, 1'b1, BF | BIR | BPC | BB);
        cyc(cond ? 1'b1 : run_end, 1'b1, 1'b1, BRD | BB | (cond ? 10'b0 : BD));
        m_cnt = cnt;
        if (cond) begin
            cyc(run_end, 1'b1, 1'b1, BA | BB | ((cls == 4'd0) ? BD : 10'b0));
            if (cls == 4'd9 || cls == 4'd10) begin
                wr = (cls == 4'd10) ? BW : 10'b0;
                for (int i = 0; i < mwait; i++) cyc(run_end, 1'b1, 1'b0, BM | wr | BB);
                cyc(run_end, 1'b1, 1'b1, BM | wr | BB | ((cls == 4'd10) ? BD : 10'b0));
            end
            if (cls != 4'd0 && cls != 4'd10) cyc(run_end, 1'b1, 1'b1, BR | BB | BD);
            m_ret = m_ret + 1'b1;
        end
        latency = lat_m;
    endtask

    initial begin
        RST          = 1'b1;
        bus.Run       = 1'b0;
        bus.Fetch_Ack = 1'b0;
        bus.Mem_Ack   = 1'b0;
        bus.Decode    = 4'd0;
        bus.CntIn     = '0;
        bus.CondPass  = 1'b1;
        m_cnt = '0;
        m_ret = '0;
        idx   = 0;
        lat_m = -1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        chk("reset_retcount", int'(bus.RetCount), 0);
        chk("reset_cntout", int'(bus.CntOut), 0);

        // ALU op, halt afterwards
        idle_cyc(1'b1);
        run_instr(4'd1, 6'b000100, 1'b1, 0, 0, 1'b0, lat);
        chk("alu_latency", lat, 4);
        chk("alu_cntout", int'(bus.CntOut), 4);
        chk("alu_retcount", int'(bus.RetCount), 1);
        idle_cyc(1'b0);

        // Load with 3 wait cycles, then back-to-back store/annul/class-0
        idle_cyc(1'b1);
        run_instr(4'd9, 6'h2A, 1'b1, 0, 3, 1'b1, lat);
        chk("load_wait_latency", lat, 8);
        chk("load_retcount", int'(bus.RetCount), 2);
        run_instr(4'd10, 6'h15, 1'b1, 2, 0, 1'b1, lat);
        chk("store_fetchwait_latency", lat, 6);
        chk("store_retcount", int'(bus.RetCount), 3);
        run_instr(4'd5, 6'h3F, 1'b0, 0, 0, 1'b1, lat);
        chk("annul_latency", lat, 2);
        chk("annul_retcount", int'(bus.RetCount), 3);
        chk("annul_cntout", int'(bus.CntOut), 63);
        run_instr(4'd0, 6'h01, 1'b1, 0, 0, 1'b0, lat);
        chk("cls0_latency", lat, 3);
        chk("cls0_retcount", int'(bus.RetCount), 4);
        idle_cyc(1'b0);

        // Reset in the middle of a stalled load; ack in the reset cycle is ignored
        idle_cyc(1'b1);
        bus.Decode   = 4'd9;
        bus.CntIn    = 6'h33;
        bus.CondPass = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, BF | BIR | BPC | BB);
        cyc(1'b1, 1'b1, 1'b0, BRD | BB);
        m_cnt = 6'h33;
        cyc(1'b1, 1'b1, 1'b0, BA | BB);
        cyc(1'b1, 1'b1, 1'b0, BM | BB);
        cyc(1'b1, 1'b0, 1'b0, BM | BB);
        bus.Mem_Ack = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        m_cnt = '0;
        m_ret = '0;
        idle_cyc(1'b0);
        chk("rst_mem_req", int'(bus.Mem_Req), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_retcount", int'(bus.RetCount), 0);

        // Count up to all-ones, then one ALU op with Run dropped in EXEC wraps to 0
        idle_cyc(1'b1);
        for (int i = 0; i < 15; i++) begin
            run_instr((i % 2 == 1) ? 4'd9 : 4'd0, 6'(i), 1'b1, 0, 0, 1'b1, lat);
            chk("b2b_latency", lat, (i % 2 == 1) ? 5 : 3);
        end
        chk("preload_retcount", int'(bus.RetCount), 15);
        run_instr(4'd2, 6'h0C, 1'b1, 0, 0, 1'b0, lat);
        chk("wrap_retcount", int'(bus.RetCount), 0);
        idle_cyc(1'b0);
        idle_cyc(1'b0);
        chk("halt_fetch_req", int'(bus.Fetch_Req), 0);
        idle_cyc(1'b0);

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
